// File: rtl/vga_display_if.sv
// Video port bundle between the VGA front-end (master) and the game loop / monitor (slave).
interface vga_display_if;
    logic [3:0]  category;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        frame_tick;

    modport master (
        input  category,
        output pixel_x, pixel_y, hsync, vsync, rgb, frame_tick
    );

    modport slave (
        output category,
        input  pixel_x, pixel_y, hsync, vsync, rgb, frame_tick
    );
endinterface

// File: rtl/vga_display.sv
// 640x480@60 VGA timing from a 100 MHz clock: one pixel per 4 clks, category sampled on phase 2,
// rgb/hsync/vsync registered together 3 clks after pixel_x/pixel_y change; no backpressure.
module vga_display #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter logic [11:0] COLOR_NONE = 12'h000,
    parameter logic [11:0] COLOR_WALL = 12'h888,
    parameter logic [11:0] COLOR_TANK = 12'h0F0,
    parameter logic [11:0] COLOR_ERR  = 12'hF0F
) (
    input  logic          clk_100mhz,
    input  logic          rst,
    vga_display_if.master vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [1:0]  phase_q, phase_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [11:0] rgb_q, rgb_d;
    logic        render_en;
    logic        video_on;

    function automatic logic [11:0] color(input logic [3:0] cat);
        case (cat)
            4'd0:    color = COLOR_NONE;
            4'd1:    color = COLOR_WALL;
            4'd2:    color = COLOR_TANK;
            default: color = COLOR_ERR;
        endcase
    endfunction

    always_comb begin
        phase_d = phase_q + 2'd1;
        x_d     = x_q;
        y_d     = y_q;
        if (phase_q == 2'd3) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // The game loop's category is settled by phase 2, so the render stage only latches then.
    always_comb begin
        render_en = (phase_q == 2'd2);
        video_on  = (x_q < H_VIS) && (y_q < V_VIS);
        rgb_d     = video_on ? color(vga.category) : 12'h000;
        hsync_d   = ~((x_q >= HS_FIRST) && (x_q <= HS_LAST));
        vsync_d   = ~((y_q >= VS_FIRST) && (y_q <= VS_LAST));
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (render_en) begin
                rgb_q   <= rgb_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        assert ((H_TOTAL <= 1023) && (V_TOTAL <= 1023))
            else $error("vga_display: timing totals exceed 10-bit counter range");
    end

    // Gated by rst so the tick is low while held in reset yet fires on the first clk after release.
    assign vga.frame_tick = ~rst && (phase_q == 2'd0) && (x_q == 10'd0) && (y_q == 10'd0);
    assign vga.pixel_x    = x_q;
    assign vga.pixel_y    = y_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.rgb        = rgb_q;

endmodule

// File: tb/tb_vga_display.sv
// Directed bench for vga_display; vertical timing is shortened to 16 lines so a whole frame fits.
module tb_vga_display;

    localparam int HV = 640;
    localparam int HT = 800;
    localparam int VV = 12;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = 4 * HT * VT;
    localparam int NVEC = 10;

    logic clk_100mhz = 1'b0;
    logic rst;

    vga_display_if vif ();

    vga_display #(
        .V_VISIBLE(VV),
        .V_FRONT  (VF),
        .V_SYNC   (VS),
        .V_BACK   (VB)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .rst       (rst),
        .vga       (vif)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        int          x;
        int          y;
        logic [3:0]  cat;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t        vecs [NVEC];
    logic [11:0] got_prev [NVEC];
    logic [11:0] got_first[NVEC];
    logic [11:0] got_last [NVEC];
    logic [11:0] got_after[NVEC];

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    int err_x = 0, err_y = 0, err_hs = 0, err_vs = 0, err_rgb = 0, err_ft = 0;
    int hs_first = -1, hs_cnt = 0, vs_cnt = 0, tick_cnt = 0, last_tick = -1;
    int y_before = -1, y_after = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cat_map(input int x, input int y);
        logic [3:0] c = 4'd0;
        for (int i = 0; i < NVEC; i++)
            if (vecs[i].x == x && vecs[i].y == y) c = vecs[i].cat;
        return c;
    endfunction

    function automatic logic [11:0] color_of(input logic [3:0] c);
        case (c)
            4'd0:    return 12'h000;
            4'd1:    return 12'h888;
            4'd2:    return 12'h0F0;
            default: return 12'hF0F;
        endcase
    endfunction

    // Only the phase-2 value is meaningful; the other phases carry a deliberately wrong class.
    task automatic drive_cat();
        int pix = t / 4;
        logic [3:0] c = cat_map(pix % HT, (pix / HT) % VT);
        vif.category = ((t % 4) == 2) ? c : (c ^ 4'hF);
    endtask

    task automatic model_check();
        int ex = (t / 4) % HT;
        int ey = (t / 4 / HT) % VT;
        logic [11:0] ergb = 12'h000;
        logic ehs = 1'b1;
        logic evs = 1'b1;
        if (t >= 3) begin
            int r  = (t - 3) / 4;
            int rx = r % HT;
            int ry = (r / HT) % VT;
            ergb = (rx < HV && ry < VV) ? color_of(cat_map(rx, ry)) : 12'h000;
            ehs  = !(rx >= 656 && rx <= 751);
            evs  = !(ry >= VV + VF && ry <= VV + VF + VS - 1);
        end
        if (int'(vif.pixel_x) != ex) err_x++;
        if (int'(vif.pixel_y) != ey) err_y++;
        if (vif.rgb !== ergb) err_rgb++;
        if (vif.hsync !== ehs) err_hs++;
        if (vif.vsync !== evs) err_vs++;
        if (vif.frame_tick !== ((t % FRAME) == 0)) err_ft++;
    endtask

    task automatic step();
        @(posedge clk_100mhz);
        #1;
        t++;
        drive_cat();
        model_check();
    endtask

    task automatic capture();
        for (int i = 0; i < NVEC; i++) begin
            int base = 4 * (vecs[i].y * HT + vecs[i].x) + 3;
            if (t == base - 1) got_prev[i]  = vif.rgb;
            if (t == base)     got_first[i] = vif.rgb;
            if (t == base + 3) got_last[i]  = vif.rgb;
            if (t == base + 4) got_after[i] = vif.rgb;
        end
        if (t < 4 * HT && !vif.hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = t;
        end
        if (!vif.vsync) vs_cnt++;
        if (vif.frame_tick) begin
            tick_cnt++;
            last_tick = t;
        end
        if (t == 4 * HT - 1) y_before = int'(vif.pixel_y);
        if (t == 4 * HT)     y_after  = int'(vif.pixel_y);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_x"}, int'(vif.pixel_x), 0);
        check({tag, "_pixel_y"}, int'(vif.pixel_y), 0);
        check({tag, "_hsync"}, int'(vif.hsync), 1);
        check({tag, "_vsync"}, int'(vif.vsync), 1);
        check({tag, "_rgb"}, int'(vif.rgb), 0);
        check({tag, "_frame_tick"}, int'(vif.frame_tick), 0);
    endtask

    initial begin
        vecs[0] = '{10,  10, 4'd1,  12'h888};
        vecs[1] = '{20,  10, 4'd2,  12'h0F0};
        vecs[2] = '{700, 10, 4'd1,  12'h000};
        vecs[3] = '{5,   10, 4'd7,  12'hF0F};
        vecs[4] = '{30,  3,  4'd15, 12'hF0F};
        vecs[5] = '{639, 11, 4'd2,  12'h0F0};
        vecs[6] = '{650, 11, 4'd1,  12'h000};
        vecs[7] = '{0,   12, 4'd1,  12'h000};
        vecs[8] = '{0,   1,  4'd3,  12'hF0F};
        vecs[9] = '{300, 5,  4'd2,  12'h0F0};
        for (int i = 0; i < NVEC; i++) begin
            got_prev[i] = 12'hFFF; got_first[i] = 12'hFFF;
            got_last[i] = 12'hFFF; got_after[i] = 12'hFFF;
        end

        vif.category = 4'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        repeat (3) @(posedge clk_100mhz);
        #1 check_reset_outputs("reset_held");

        rst = 1'b0;
        t = 0;
        drive_cat();
        #1;
        model_check();
        capture();
        for (int i = 1; i <= FRAME; i++) begin
            step();
            capture();
        end

        for (int i = 0; i < NVEC; i++) begin
            string nm = $sformatf("vec%0d_x%0d_y%0d", i, vecs[i].x, vecs[i].y);
            check({nm, "_first"}, int'(got_first[i]), int'(vecs[i].exp_rgb));
            check({nm, "_last"},  int'(got_last[i]),  int'(vecs[i].exp_rgb));
            check({nm, "_prev"},  int'(got_prev[i]),  0);
            check({nm, "_after"}, int'(got_after[i]), 0);
        end

        check("hsync_first_low_clk", hs_first, 4 * 656 + 3);
        check("hsync_low_clks", hs_cnt, 384);
        check("vsync_low_clks", vs_cnt, 2 * 3200);
        check("frame_tick_count", tick_cnt, 2);
        check("frame_tick_period", last_tick, FRAME);
        check("pixel_y_before_wrap", y_before, 0);
        check("pixel_y_after_wrap", y_after, 1);

        // Mid-frame reset at x=301,y=5 while pixel 300 (tank colour) is still on the output.
        while (t < FRAME + 4 * (5 * HT + 300) + 4) step();
        check("pre_reset_pixel_x", int'(vif.pixel_x), 301);
        check("pre_reset_rgb", int'(vif.rgb), 12'h0F0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset_async");
        repeat (2) @(posedge clk_100mhz);
        #1 check_reset_outputs("mid_reset_held");
        rst = 1'b0;
        t = 0;
        drive_cat();
        #1;
        check("post_release_tick", int'(vif.frame_tick), 1);
        check("post_release_pixel_x", int'(vif.pixel_x), 0);
        check("post_release_pixel_y", int'(vif.pixel_y), 0);
        model_check();
        step();
        check("post_release_tick_drop", int'(vif.frame_tick), 0);
        for (int i = 0; i < 40; i++) step();

        check("stream_pixel_x_errs", err_x, 0);
        check("stream_pixel_y_errs", err_y, 0);
        check("stream_rgb_errs", err_rgb, 0);
        check("stream_hsync_errs", err_hs, 0);
        check("stream_vsync_errs", err_vs, 0);
        check("stream_frame_tick_errs", err_ft, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_display.md
Name: vga_display

Overview:
- Video front-end of the tank game. Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Drives `pixel_x`/`pixel_y` into the game-loop stage, which returns a registered 4-bit cell `category` one clock later.
- Converts that category to 12-bit RGB, phase-aligned with delayed `hsync`/`vsync`.
- Also emits a once-per-frame tick for game logic.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- COLOR_NONE, 12'h000, RGB for category 0 (background)
- COLOR_WALL, 12'h888, RGB for category 1 (wall)
- COLOR_TANK, 12'h0F0, RGB for category 2 (tank)
- COLOR_ERR, 12'hF0F, RGB for categories 3..15

Ports:
- clk_100mhz input 1: system clock; all state changes on its rising edge
- rst input 1: asynchronous, active-high reset
- category input 4: cell class for the current pixel_x/pixel_y; valid 1 clk after those change
- pixel_x output 10: current horizontal count 0..799 (to game loop)
- pixel_y output 10: current vertical count 0..524 (to game loop)
- hsync output 1: horizontal sync, active low
- vsync output 1: vertical sync, active low
- rgb output 12: {R[3:0],G[3:0],B[3:0]}
- frame_tick output 1: one-clk pulse at the start of each frame

Behaviour:
- Reset values (asserted asynchronously, held while rst=1):
  - phase=0, pixel_x=0, pixel_y=0
  - hsync=1, vsync=1, rgb=0, frame_tick=0
  - all internal pipeline registers cleared, with sync registers at the inactive level (1)
- Pixel phase:
  - A 2-bit counter `phase` increments every clk and wraps 3->0, giving one 25 MHz pixel every 4 clks.
- Counter advance (only on the clk where phase==3):
  - pixel_x increments.
  - At H_TOTAL-1=799 it wraps to 0 and pixel_y increments.
  - pixel_y wraps at V_TOTAL-1=524 to 0.
  - H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is formed likewise.
  - pixel_x and pixel_y therefore change only on phase 3->0 edges and are stable for phases 0..3.
- Category timing:
  - category is registered by the game loop, so it is valid from phase 1 onward.
  - The block samples it on the clk where phase==2.
- Render stage (registered; updates only on the phase==2 clk):
  - video_on = (pixel_x < H_VISIBLE) && (pixel_y < V_VISIBLE), computed from the current counters.
  - rgb = video_on ? color(category) : 12'h000.
  - color() maps category 0 to COLOR_NONE, 1 to COLOR_WALL, 2 to COLOR_TANK, and any other value to COLOR_ERR.
  - hsync = ~(pixel_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for x in 656..751.
  - vsync = ~(pixel_y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. low for y in 490..491.
  - rgb, hsync and vsync therefore change together, 3 clks after pixel_x/pixel_y change, and hold for 4 clks.
- frame_tick:
  - High for exactly one clk: the clk where phase==0 and pixel_x==0 and pixel_y==0.
  - Frequency = 100e6/(4*800*525) ≈ 59.52 Hz.
- Arithmetic:
  - All comparisons are unsigned 10-bit.
  - Parameter sums must stay ≤ 1023; this is checked by a simulation assertion.
- Reset mid-frame: all outputs go to reset values immediately (asynchronously). After release, counting restarts at x=0, y=0, phase=0. The first frame_tick occurs on the first clk after release.
- Category changes mid-pixel (phases 0, 1, 3): ignored. Only the phase-2 sample matters.
- Blanking region: rgb is forced to 0 regardless of category.

Test Plan:
- Reset release, then run 4*800 clks -> pixel_x steps 0..799 once, each value held 4 clks; pixel_y goes 0->1 on clk 3200; frame_tick high only on the first clk.
- Hsync check over one line -> hsync low for exactly 96*4=384 clks, starting 3 clks after pixel_x becomes 656.
- Full frame of 1,680,000 clks -> vsync low for 2*3200 clks starting at y=490; frame_tick period exactly 1,680,000 clks.
- Drive category=1 at x=10,y=10, category=2 at x=20,y=10, 0 elsewhere -> rgb = 12'h888 then 12'h0F0, each appearing 3 clks after the matching pixel_x, held 4 clks.
- Drive category=1 at x=700, and category=7 at x=5 -> rgb stays 0 at x=700 (blanking); rgb=12'hF0F at x=5.
- Assert rst mid-line at x=300,y=200 -> outputs at reset values within the same clk (no edge required); after release pixel_x=0, pixel_y=0 and frame_tick pulses on the next clk.
